// File: rtl/accel_pkg.sv
// Shared definitions for the systolic-array job controller: state encoding,
// registered output bundle and the array-size-derived phase lengths.
package accel_pkg;

  // Default systolic array dimension N (legal range 2..64).
  localparam int unsigned ARRAYWIDTH_DEFAULT = 8;

  // Phase lengths for the default array size.
  localparam int unsigned COMPUTE_LEN = 3 * ARRAYWIDTH_DEFAULT - 1;
  localparam int unsigned FEED_LEN    = 2 * ARRAYWIDTH_DEFAULT - 1;
  localparam int unsigned JOB_LEN     = 7 * ARRAYWIDTH_DEFAULT;

  // Controller states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_X,
    S_PRELOAD,
    S_COMPUTE,
    S_DRAIN,
    S_DONE
  } accel_state_t;

  // Registered control outputs, grouped so they can be cleared in one step.
  typedef struct packed {
    logic input_buffer_load_en;
    logic input_buffer_out_en;
    logic weight_buffer_load_en;
    logic weight_buffer_out_en;
    logic write_weight_en;
    logic output_buffer_load_en;
    logic output_buffer_out_en;
    logic relu_en;
    logic softmax_en;
    logic w_req;
    logic x_req;
    logic busy;
    logic done;
  } accel_out_t;

  // COMPUTE phase length for an array of dimension n.
  function automatic int unsigned compute_len(input int unsigned n);
    return 3 * n - 1;
  endfunction

  // Number of COMPUTE cycles during which activations are fed in.
  function automatic int unsigned feed_len(input int unsigned n);
    return 2 * n - 1;
  endfunction

  // Cycles from start acceptance to the done pulse.
  function automatic int unsigned job_len(input int unsigned n);
    return 7 * n;
  endfunction

  // Width of the shared phase counter: holds 0..3n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(3 * n);
  endfunction

endpackage

// File: rtl/accel_ctrl.sv
// Job controller for an NxN systolic array: sequences weight load, activation
// load, weight preload, compute and drain phases, then pulses done.
module accel_ctrl
  import accel_pkg::*;
#(
  parameter int unsigned ARRAYWIDTH = ARRAYWIDTH_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic relu_mode,
  input  logic softmax_mode,
  output logic input_buffer_load_en,
  output logic input_buffer_out_en,
  output logic weight_buffer_load_en,
  output logic weight_buffer_out_en,
  output logic write_weight_en,
  output logic output_buffer_load_en,
  output logic output_buffer_out_en,
  output logic relu_en,
  output logic softmax_en,
  output logic w_req,
  output logic x_req,
  output logic busy,
  output logic done
);

  localparam int unsigned CW = cnt_width(ARRAYWIDTH);

  localparam logic [CW-1:0] PHASE_LAST   = CW'(ARRAYWIDTH - 1);
  localparam logic [CW-1:0] COMPUTE_LAST = CW'(compute_len(ARRAYWIDTH) - 1);
  localparam logic [CW-1:0] FEED_END     = CW'(feed_len(ARRAYWIDTH));
  localparam logic [CW-1:0] COLLECT_BEG  = CW'(ARRAYWIDTH);

  accel_state_t r_state;
  accel_state_t w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_relu;
  logic          r_softmax;
  logic          w_relu_nxt;
  logic          w_softmax_nxt;
  accel_out_t    r_out;
  accel_out_t    w_out_nxt;

  // Next-state and counter logic; abort from any busy state wins over everything.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + CW'(1);
    w_relu_nxt    = r_relu;
    w_softmax_nxt = r_softmax;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (start && !abort) begin
          w_state_nxt   = S_LOAD_W;
          w_relu_nxt    = relu_mode;
          w_softmax_nxt = softmax_mode;
        end
      end
      S_LOAD_W: begin
        if (r_cnt == PHASE_LAST) begin
          w_state_nxt = S_LOAD_X;
          w_cnt_nxt   = '0;
        end
      end
      S_LOAD_X: begin
        if (r_cnt == PHASE_LAST) begin
          w_state_nxt = S_PRELOAD;
          w_cnt_nxt   = '0;
        end
      end
      S_PRELOAD: begin
        if (r_cnt == PHASE_LAST) begin
          w_state_nxt = S_COMPUTE;
          w_cnt_nxt   = '0;
        end
      end
      S_COMPUTE: begin
        if (r_cnt == COMPUTE_LAST) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = '0;
        end
      end
      S_DRAIN: begin
        if (r_cnt == PHASE_LAST) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end
  end

  // Output decode from the upcoming state so the registered outputs line up with it.
  always_comb begin
    w_out_nxt = '0;
    unique case (w_state_nxt)
      S_IDLE: begin
        w_out_nxt = '0;
      end
      S_LOAD_W: begin
        w_out_nxt.weight_buffer_load_en = 1'b1;
        w_out_nxt.w_req                 = 1'b1;
      end
      S_LOAD_X: begin
        w_out_nxt.input_buffer_load_en = 1'b1;
        w_out_nxt.x_req                = 1'b1;
      end
      S_PRELOAD: begin
        w_out_nxt.weight_buffer_out_en = 1'b1;
        w_out_nxt.write_weight_en      = 1'b1;
      end
      S_COMPUTE: begin
        w_out_nxt.input_buffer_out_en   = (w_cnt_nxt < FEED_END);
        w_out_nxt.output_buffer_load_en = (w_cnt_nxt >= COLLECT_BEG);
      end
      S_DRAIN: begin
        w_out_nxt.output_buffer_out_en = 1'b1;
        w_out_nxt.softmax_en           = w_softmax_nxt;
        w_out_nxt.relu_en              = w_relu_nxt && !w_softmax_nxt;
      end
      S_DONE: begin
        w_out_nxt.done = 1'b1;
      end
      default: begin
        w_out_nxt = '0;
      end
    endcase
    w_out_nxt.busy = (w_state_nxt != S_IDLE);
  end

  // State, counter, latched modes and output register bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_relu    <= 1'b0;
      r_softmax <= 1'b0;
      r_out     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_relu    <= w_relu_nxt;
      r_softmax <= w_softmax_nxt;
      r_out     <= w_out_nxt;
    end
  end

  assign input_buffer_load_en  = r_out.input_buffer_load_en;
  assign input_buffer_out_en   = r_out.input_buffer_out_en;
  assign weight_buffer_load_en = r_out.weight_buffer_load_en;
  assign weight_buffer_out_en  = r_out.weight_buffer_out_en;
  assign write_weight_en       = r_out.write_weight_en;
  assign output_buffer_load_en = r_out.output_buffer_load_en;
  assign output_buffer_out_en  = r_out.output_buffer_out_en;
  assign relu_en               = r_out.relu_en;
  assign softmax_en            = r_out.softmax_en;
  assign w_req                 = r_out.w_req;
  assign x_req                 = r_out.x_req;
  assign busy                  = r_out.busy;
  assign done                  = r_out.done;

endmodule

// File: tb/tb_accel_ctrl.sv
// Bench for accel_ctrl: two instances (N=4 and N=2) share stimulus and are
// checked every cycle against a job-timeline reference model.
module tb_accel_ctrl;

  localparam int unsigned NA = 4;
  localparam int unsigned NB = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic relu_mode = 1'b0;
  logic softmax_mode = 1'b0;

  // Bit order: ibl ibo wbl wbo ww obl obo relu softmax wreq xreq busy done
  wire [12:0] oa;
  wire [12:0] ob;

  int vec = 0;
  int errs = 0;

  // Model: position in the job timeline (-1 = idle) and latched modes, per DUT.
  int pos [2];
  bit lr [2];
  bit ls [2];

  accel_ctrl #(.ARRAYWIDTH(NA)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .relu_mode(relu_mode), .softmax_mode(softmax_mode),
    .input_buffer_load_en(oa[12]), .input_buffer_out_en(oa[11]),
    .weight_buffer_load_en(oa[10]), .weight_buffer_out_en(oa[9]),
    .write_weight_en(oa[8]), .output_buffer_load_en(oa[7]),
    .output_buffer_out_en(oa[6]), .relu_en(oa[5]), .softmax_en(oa[4]),
    .w_req(oa[3]), .x_req(oa[2]), .busy(oa[1]), .done(oa[0])
  );

  accel_ctrl #(.ARRAYWIDTH(NB)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .relu_mode(relu_mode), .softmax_mode(softmax_mode),
    .input_buffer_load_en(ob[12]), .input_buffer_out_en(ob[11]),
    .weight_buffer_load_en(ob[10]), .weight_buffer_out_en(ob[9]),
    .write_weight_en(ob[8]), .output_buffer_load_en(ob[7]),
    .output_buffer_out_en(ob[6]), .relu_en(ob[5]), .softmax_en(ob[4]),
    .w_req(ob[3]), .x_req(ob[2]), .busy(ob[1]), .done(ob[0])
  );

  always #5 clk = ~clk;

  // Expected outputs at offset o after the accepting edge of a job on an NxN array.
  function automatic logic [12:0] expv(input int o, input int n, input bit r, input bit s);
    logic ibl, ibo, wbl, wbo, ww, obl, obo, re, so, wr, xr, bz, dn;
    wr  = (o >= 0)         && (o < n);
    wbl = wr;
    xr  = (o >= n)         && (o < 2*n);
    ibl = xr;
    wbo = (o >= 2*n)       && (o < 3*n);
    ww  = wbo;
    ibo = (o >= 3*n)       && (o < 3*n + 2*n - 1);
    obl = (o >= 3*n + n)   && (o < 6*n - 1);
    obo = (o >= 6*n - 1)   && (o < 7*n - 1);
    so  = obo && s;
    re  = obo && r && !s;
    dn  = (o == 7*n - 1);
    bz  = (o >= 0)         && (o <= 7*n - 1);
    return {ibl, ibo, wbl, wbo, ww, obl, obo, re, so, wr, xr, bz, dn};
  endfunction

  function automatic int dim(input int d);
    return (d == 0) ? int'(NA) : int'(NB);
  endfunction

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      pos[d] = -1;
      lr[d]  = 1'b0;
      ls[d]  = 1'b0;
    end
  endtask

  // One clock edge: advance the model on the sampled inputs, then compare.
  task automatic step();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        pos[d] = -1; lr[d] = 1'b0; ls[d] = 1'b0;
      end else if (pos[d] < 0) begin
        if (start && !abort) begin
          pos[d] = 0; lr[d] = relu_mode; ls[d] = softmax_mode;
        end
      end else if (abort) begin
        pos[d] = -1;
      end else begin
        pos[d] = pos[d] + 1;
        if (pos[d] > 7*dim(d) - 1) pos[d] = -1;
      end
    end
    #1;
    chk("cycle_n4", oa, expv(pos[0], dim(0), lr[0], ls[0]));
    chk("cycle_n2", ob, expv(pos[1], dim(1), lr[1], ls[1]));
  endtask

  int lat;
  int cnt_wl, cnt_xl, cnt_ww, cnt_ibo, cnt_obl, cnt_obo, cnt_sm, cnt_re;

  initial begin
    model_reset();
    #2;
    chk("reset_n4", oa, 13'd0);
    chk("reset_n2", ob, 13'd0);
    #10 rst = 1'b1;

    // Basic job, N=4 latency and N=2 enable duty counts.
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    cnt_wl = 0; cnt_xl = 0; cnt_ww = 0; cnt_ibo = 0; cnt_obl = 0; cnt_obo = 0;
    cnt_wl += ob[10]; cnt_xl += ob[12]; cnt_ww += ob[8];
    for (int i = 0; i < 60; i++) begin
      step();
      lat++;
      cnt_wl += ob[10]; cnt_xl += ob[12]; cnt_ww += ob[8];
      cnt_ibo += ob[11]; cnt_obl += ob[7]; cnt_obo += ob[6];
      if (oa[0]) break;
    end
    chk_int("latency_n4", lat, 7*NA - 1);
    chk_int("n2_wload_cnt", cnt_wl, NB);
    chk_int("n2_xload_cnt", cnt_xl, NB);
    chk_int("n2_wwrite_cnt", cnt_ww, NB);
    chk_int("n2_ibuf_out_cnt", cnt_ibo, 2*NB - 1);
    chk_int("n2_obuf_load_cnt", cnt_obl, 2*NB - 1);
    chk_int("n2_obuf_out_cnt", cnt_obo, NB);
    repeat (3) step();

    // Both modes at start: softmax wins; mode wiggles mid-job are ignored.
    relu_mode = 1'b1; softmax_mode = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    cnt_sm = 0; cnt_re = 0;
    for (int i = 0; i < 30; i++) begin
      relu_mode = 1'($urandom_range(0, 1));
      softmax_mode = 1'($urandom_range(0, 1));
      step();
      cnt_sm += oa[4]; cnt_re += oa[5];
    end
    chk_int("softmax_cnt", cnt_sm, NA);
    chk_int("relu_cnt", cnt_re, 0);

    // Relu only.
    relu_mode = 1'b1; softmax_mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0; relu_mode = 1'b0;
    repeat (30) step();

    // Abort mid-job, then abort+start together in idle, then a fresh job.
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (13) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_clear", oa, 13'd0);
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    chk("abort_start_idle", oa, 13'd0);
    repeat (4) step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (30) step();

    // Start held for 40 cycles: re-accepted only after done.
    start = 1'b1;
    repeat (40) step();
    start = 1'b0;
    repeat (30) step();

    // Asynchronous reset mid-COMPUTE, then a normal job.
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (15) step();
    #2 rst = 1'b0;
    #1;
    chk("async_rst_n4", oa, 13'd0);
    chk("async_rst_n2", ob, 13'd0);
    model_reset();
    step();
    rst = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (30) step();

    // Randomized traffic with occasional aborts and resets.
    for (int i = 0; i < 1500; i++) begin
      start        = ($urandom_range(0, 7) == 0);
      abort        = ($urandom_range(0, 60) == 0);
      relu_mode    = 1'($urandom_range(0, 1));
      softmax_mode = 1'($urandom_range(0, 1));
      rst          = ($urandom_range(0, 300) != 0);
      step();
    end
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
